// File: rtl/fizzbuzz_pkg.sv
// fizzbuzz_pkg: generator flag model and decoder state type shared by the decoder and its bench.
package fizzbuzz_pkg;
  typedef enum logic {FB_HUNT, FB_LOCKED} fb_state_e;
  // Flag triple {fizz, buzz, fb} that the generator emits at index i.
  function automatic logic [2:0] fb_expected(input int i, input int fizz, input int buzz);
    logic f, b;
    f = (i % fizz) == 0;
    b = (i % buzz) == 0;
    return {f, b, f & b};
  endfunction
endpackage

// File: rtl/fb_onehot_index.sv
// fb_onehot_index: zero / exactly-one / many reduction over a candidate vector plus the set-bit position.
module fb_onehot_index #(
  parameter int N = 100,
  localparam int W = (N > 1) ? $clog2(N) : 1
)(
  input  logic [N-1:0] cand,
  output logic         is_zero,
  output logic         is_onehot,
  output logic [W-1:0] idx
);
  logic many;
  // OR of set positions equals the position whenever exactly one bit is set.
  always_comb begin
    is_zero = 1'b1;
    many = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      many = many | (cand[i] & ~is_zero);
      is_zero = is_zero & ~cand[i];
      idx = idx | (cand[i] ? W'(i) : '0);
    end
    is_onehot = ~is_zero & ~many;
  end
endmodule

// File: rtl/fizzbuzz_decoder.sv
// fizzbuzz_decoder: recovers the generator index from the fizz/buzz/fb flag stream alone.
module fizzbuzz_decoder
  import fizzbuzz_pkg::*;
#(
  parameter int FIZZ = 3,
  parameter int BUZZ = 5,
  parameter int MAX_CYCLES = 100,
  parameter int ERR_W = 8
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          in_fizz,
  input  logic                          in_buzz,
  input  logic                          in_fb,
  output logic                          locked,
  output logic [$clog2(MAX_CYCLES)-1:0] index,
  output logic                          err,
  output logic [ERR_W-1:0]              err_count
);
  localparam int IW = $clog2(MAX_CYCLES);
  fb_state_e state;
  logic [MAX_CYCLES-1:0] cand, match, nxt;
  logic nxt_zero, nxt_one;
  logic [IW-1:0] nxt_idx;
  for (genvar i = 0; i < MAX_CYCLES; i++) begin : g_match
    assign match[i] = {in_fizz, in_buzz, in_fb} == fb_expected(i, FIZZ, BUZZ);
  end
  // Rotate by one models i-1 -> i, including the MAX_CYCLES-1 -> 0 wrap.
  assign nxt = {cand[MAX_CYCLES-2:0], cand[MAX_CYCLES-1]} & match;
  fb_onehot_index #(.N(MAX_CYCLES)) u_onehot (
    .cand(nxt),
    .is_zero(nxt_zero),
    .is_onehot(nxt_one),
    .idx(nxt_idx)
  );
  assign locked = state == FB_LOCKED;
  always_ff @(posedge clk) begin
    err <= 1'b0;
    if (reset) begin
      cand <= '1;
      state <= FB_HUNT;
      index <= '0;
      err_count <= '0;
    end else if (in_valid) begin
      cand <= nxt_zero ? '1 : nxt;
      state <= nxt_one ? FB_LOCKED : FB_HUNT;
      index <= nxt_one ? nxt_idx : '0;
      err <= nxt_zero;
      err_count <= err_count + ERR_W'(nxt_zero && err_count != '1);
    end
  end
endmodule

// File: tb/tb_fizzbuzz_decoder.sv
// tb_fizzbuzz_decoder: scoreboarded directed streams against the default decoder and a MAX_CYCLES=90 instance.
module tb_fizzbuzz_decoder;
  logic clk = 0, reset = 1, in_valid = 0, in_fizz = 0, in_buzz = 0, in_fb = 0;
  logic locked, err;
  logic [6:0] index;
  logic [7:0] err_count;
  logic v90 = 0, f90 = 0, b90 = 0, fb90 = 0;
  logic l90, e90;
  logic [6:0] i90;
  logic [7:0] c90;
  int checks = 0, errors = 0;
  bit done90 = 0;
  typedef struct {bit chk_l; bit lk; int idx; bit er; bit chk_c; int cnt;} exp_t;
  exp_t q[$];

  fizzbuzz_decoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_fizz(in_fizz), .in_buzz(in_buzz),
    .in_fb(in_fb), .locked(locked), .index(index), .err(err), .err_count(err_count)
  );
  fizzbuzz_decoder #(.MAX_CYCLES(90)) dut90 (
    .clk(clk), .reset(reset), .in_valid(v90), .in_fizz(f90), .in_buzz(b90),
    .in_fb(fb90), .locked(l90), .index(i90), .err(e90), .err_count(c90)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] gen(input int i);
    return {i % 3 == 0, i % 5 == 0, i % 15 == 0};
  endfunction

  function automatic exp_t ex(bit chk_l, bit lk, int idx, bit er, bit chk_c, int cnt);
    exp_t e;
    e.chk_l = chk_l; e.lk = lk; e.idx = idx; e.er = er; e.chk_c = chk_c; e.cnt = cnt;
    return e;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic send(input logic [2:0] fl, input exp_t e);
    @(negedge clk);
    in_valid = 1;
    {in_fizz, in_buzz, in_fb} = fl;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected beats never observed", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    in_valid = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    bit b;
    exp_t e;
    forever begin
      @(posedge clk);
      b = in_valid && !reset;
      #1;
      if (b) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: beat with empty queue at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("err", err, e.er);
          if (e.chk_l) begin
            chk("locked", locked, e.lk);
            if (e.lk) chk("index", index, e.idx);
            else chk("index_unlocked", index, 0);
          end
          if (e.chk_c) chk("err_count", err_count, e.cnt);
        end
      end else if (!reset) chk("idle_err", err, 0);
    end
  end

  initial begin
    bit b;
    forever begin
      @(posedge clk);
      b = v90 && !reset;
      #1;
      if (b) begin
        chk("m90_locked", l90, 0);
        chk("m90_err", e90, 0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      v90 = 1;
      {f90, b90, fb90} = gen(k % 90);
    end
    @(negedge clk);
    v90 = 0;
    done90 = 1;
  end

  initial begin
    int idx;
    bit lk;
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_index", index, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    // aligned stream from index 0: seven candidates remain until the wrap resolves them
    for (int b = 1; b <= 140; b++) begin
      idx = (b - 1) % 100;
      lk = b >= 86;
      send(gen(idx), ex(1, lk, lk ? idx : 0, 0, 1, 0));
    end
    // index 40 with fizz forced high gives a malformed triple
    send(gen(40) | 3'b100, ex(1, 0, 0, 1, 1, 1));
    for (int k = 1; k <= 110; k++) begin
      idx = (40 + k) % 100;
      send(gen(idx), ex(k > 100, 1, idx, 0, 1, 1));
    end
    drain();
    @(negedge clk);
    reset = 1;
    in_valid = 1;
    {in_fizz, in_buzz, in_fb} = gen(51);
    @(negedge clk);
    chk("midlock_rst_locked", locked, 0);
    chk("midlock_rst_index", index, 0);
    chk("midlock_rst_err_count", err_count, 0);
    chk("midlock_rst_err", err, 0);
    reset = 0;
    in_valid = 0;
    // same stream with idle gaps between beats
    do_reset();
    for (int b = 1; b <= 130; b++) begin
      idx = (b - 1) % 100;
      lk = b >= 86;
      send(gen(idx), ex(1, lk, lk ? idx : 0, 0, 1, 0));
      idle($urandom_range(0, 3));
    end
    drain();
    // fb without fizz never matches; counter saturates
    do_reset();
    for (int k = 1; k <= 261; k++) send(3'b011, ex(1, 0, 0, 1, 1, k > 255 ? 255 : k));
    drain();
    for (int k = 0; k < 5000 && !done90; k++) @(negedge clk);
    if (!done90) begin
      errors++;
      $display("FAIL m90_stream: stimulus did not complete");
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
